hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5; busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10; busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 IR_D  input  32  instruction in decode stage.
REQ-006 STALL  output  1  freeze PC/IF-D registers and insert a bubble into E.
REQ-007 DST_E, DST_M, DST_W  output  5 each  destination register tag per stage; 0 means no write.
REQ-008 TNEW_E, TNEW_M  output  2 each  cycles until the stage's result is forwardable.
REQ-009 MD_BUSY  output  1  multiply/divide unit occupied.

Function
REQ-010 Decode IR_D as follows:
- cal_r (op 0, func not 0 and not 0x08): dst rd, Tnew 1, Tuse rs/rt 1.
- ori/lui (op 0x0D/0x0F): dst rt, Tnew 1, Tuse rs 1.
- lw (0x23): dst rt, Tnew 2, Tuse rs 1.
- sw (0x2B): no dst, Tuse rs 1, rt 2.
- beq (0x04): no dst, Tuse rs/rt 0.
- jr (op 0, func 0x08): no dst, Tuse rs 0.
- jal (0x03): dst 31, Tnew 0.
- Anything else: no dst, no use.
REQ-011 STALL SHALL be combinational. It is asserted when a used, nonzero source register equals DST_E with TNEW_E > Tuse, or equals DST_M with TNEW_M > Tuse.
REQ-012 Register 0 SHALL never cause a stall.
REQ-013 A W-stage match SHALL never cause a stall.
REQ-014 On each edge, E SHALL load the decoded dst/Tnew of IR_D; when STALL=1, E SHALL load a bubble (dst 0, Tnew 0) instead.
REQ-015 On each edge, M SHALL load E's dst with Tnew = max(TNEW_E-1, 0).
REQ-016 On each edge, W SHALL load M's dst; W's Tnew is implicitly 0.
REQ-017 Pipeline advance SHALL occur every cycle; STALL only affects the D->E transfer. Latency D to W is 3 edges.
REQ-018 When D matches both E and M, the stall decision SHALL use the OR of both conditions; there is no priority.

Reset
REQ-019 While rst_n=0: DST_E/M/W=0, TNEW_E/M=0, busy counter=0, MD_BUSY=0.
REQ-020 With the pipeline empty, STALL SHALL depend only on IR_D, so it equals 0 after reset.
REQ-021 Reset asserted mid-operation SHALL immediately clear all tags and abort any mult/div count.

Configuration
REQ-022 Macro MULTDIV_EN SHALL control the multiply/divide feature.
REQ-023 When MULTDIV_EN is defined:
- func 0x18/0x19 decode as mult, 0x1A/0x1B as div; both are no-dst with Tuse rs/rt 1.
- func 0x10/0x12 (mfhi/mflo) decode as cal_r (dst rd); 0x11/0x13 (mthi/mtlo) are no-dst with Tuse rs 1.
- A 4-bit counter loads MULT_CYCLES or DIV_CYCLES when a mult/div enters E unstalled, and decrements to 0.
- MD_BUSY = (counter != 0).
- STALL is additionally asserted when D holds any of the eight md-family instructions and MD_BUSY=1.
REQ-024 When MULTDIV_EN is undefined: no counter is built, MD_BUSY is tied 0, and the md funcs decode as generic cal_r.

Structure
REQ-025 Package hazard_pkg SHALL hold:
- opcode/func constants;
- the instruction-class enum;
- Tnew/Tuse widths;
- MULT_CYCLES/DIV_CYCLES defaults.
REQ-026 Sub-module hazard_decode SHALL be the purely combinational IR_D classifier (dst, Tnew, Tuse_rs, Tuse_rt, md flags).

Verification
REQ-027 lw $1 then add $2,$1,$3 in the next cycle -> STALL=1 for exactly 1 cycle, DST_E=0 in the bubble, then no stall.
REQ-028 ori $5 then beq $5,$0 -> STALL=1 for 1 cycle; with one gap instruction between them, STALL=0.
REQ-029 lw $0 then add $2,$0,$0 -> STALL=0.
REQ-030 jal then jr $31 -> STALL=0, DST_E=31, TNEW_E=0.
REQ-031 With MULTDIV_EN, mult then mflo immediately -> MD_BUSY=1 for 5 cycles and STALL=1 on mflo until MD_BUSY falls; div gives 10 cycles.
REQ-032 Assert rst_n low during a div count -> MD_BUSY=0 and all DST=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the MIPS-style hazard scoreboard.
// MULTDIV_EN enables the multiply/divide family decode and busy counter.
package hazard_pkg;

  localparam int REG_W     = 5;
  localparam int TNEW_W    = 2;
  localparam int TUSE_W    = 2;
  localparam int MD_CNT_W  = 4;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

`ifdef MULTDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_NOP     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef enum logic [3:0] {
    IC_NONE,
    IC_CAL_R,
    IC_CAL_I,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JR,
    IC_JAL,
    IC_MULT,
    IC_DIV,
    IC_MT,
    IC_MF
  } iclass_e;

endpackage

// File: rtl/hazard_decode.sv
// Purely combinational classifier for the decode-stage instruction:
// destination tag, Tnew, source Tuse values and multiply/divide flags.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0]       ir,
  output logic [REG_W-1:0]  dst,
  output logic [TNEW_W-1:0] tnew,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic              rs_use,
  output logic              rt_use,
  output logic [TUSE_W-1:0] tuse_rs,
  output logic [TUSE_W-1:0] tuse_rt,
  output logic              is_md,
  output logic              is_mult,
  output logic              is_div
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [REG_W-1:0] rd;
  iclass_e          cls;
  logic             unused_shamt;

  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign fn = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    cls = IC_NONE;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_JR)                                   cls = IC_JR;
        else if (fn == FN_NOP)                             cls = IC_NONE;
        else if (MD_EN && (fn == FN_MULT || fn == FN_MULTU)) cls = IC_MULT;
        else if (MD_EN && (fn == FN_DIV  || fn == FN_DIVU))  cls = IC_DIV;
        else if (MD_EN && (fn == FN_MTHI || fn == FN_MTLO))  cls = IC_MT;
        else if (MD_EN && (fn == FN_MFHI || fn == FN_MFLO))  cls = IC_MF;
        else                                               cls = IC_CAL_R;
      end
      OP_ORI, OP_LUI: cls = IC_CAL_I;
      OP_LW:          cls = IC_LOAD;
      OP_SW:          cls = IC_STORE;
      OP_BEQ:         cls = IC_BRANCH;
      OP_JAL:         cls = IC_JAL;
      default:        cls = IC_NONE;
    endcase
  end

  always_comb begin
    dst     = '0;
    tnew    = '0;
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    tuse_rs = '0;
    tuse_rt = '0;
    case (cls)
      IC_CAL_R, IC_MF: begin
        dst     = rd;
        tnew    = 2'd1;
        rs_use  = 1'b1;
        rt_use  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
      end
      IC_CAL_I: begin
        dst     = rt;
        tnew    = 2'd1;
        rs_use  = 1'b1;
        tuse_rs = 2'd1;
      end
      IC_LOAD: begin
        dst     = rt;
        tnew    = 2'd2;
        rs_use  = 1'b1;
        tuse_rs = 2'd1;
      end
      IC_STORE: begin
        rs_use  = 1'b1;
        rt_use  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      IC_BRANCH: begin
        rs_use  = 1'b1;
        rt_use  = 1'b1;
      end
      IC_JR: begin
        rs_use  = 1'b1;
      end
      IC_JAL: begin
        dst     = 5'd31;
      end
      IC_MULT, IC_DIV: begin
        rs_use  = 1'b1;
        rt_use  = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
      end
      IC_MT: begin
        rs_use  = 1'b1;
        tuse_rs = 2'd1;
      end
      default: ;
    endcase
  end

  assign is_mult = (cls == IC_MULT);
  assign is_div  = (cls == IC_DIV);
  assign is_md   = (cls == IC_MULT) || (cls == IC_DIV) || (cls == IC_MT) || (cls == IC_MF);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse stall scoreboard tracking destination tags through E/M/W.
// MULTDIV_EN adds the multiply/divide busy counter and its stall term.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IR_D,
  output logic              STALL,
  output logic [REG_W-1:0]  DST_E,
  output logic [REG_W-1:0]  DST_M,
  output logic [REG_W-1:0]  DST_W,
  output logic [TNEW_W-1:0] TNEW_E,
  output logic [TNEW_W-1:0] TNEW_M,
  output logic              MD_BUSY
);

  logic [REG_W-1:0]  dec_dst;
  logic [TNEW_W-1:0] dec_tnew;
  logic [REG_W-1:0]  rs_d;
  logic [REG_W-1:0]  rt_d;
  logic              rs_use;
  logic              rt_use;
  logic [TUSE_W-1:0] tuse_rs;
  logic [TUSE_W-1:0] tuse_rt;
  logic              is_md;
  logic              is_mult;
  logic              is_div;
  logic              rs_hit;
  logic              rt_hit;
  logic              stall_md;

  hazard_decode u_decode (
    .ir      (IR_D),
    .dst     (dec_dst),
    .tnew    (dec_tnew),
    .rs      (rs_d),
    .rt      (rt_d),
    .rs_use  (rs_use),
    .rt_use  (rt_use),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .is_md   (is_md),
    .is_mult (is_mult),
    .is_div  (is_div)
  );

  // W is never checked: its result is always forwardable.
  function automatic logic src_hazard(
    input logic [REG_W-1:0]  src,
    input logic              used,
    input logic [TUSE_W-1:0] tuse,
    input logic [REG_W-1:0]  dst_e,
    input logic [TNEW_W-1:0] tnew_e,
    input logic [REG_W-1:0]  dst_m,
    input logic [TNEW_W-1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == dst_e) && (tnew_e > tuse);
    hit_m = (src == dst_m) && (tnew_m > tuse);
    return used && (src != '0) && (hit_e || hit_m);
  endfunction

  always_comb begin
    rs_hit = src_hazard(rs_d, rs_use, tuse_rs, DST_E, TNEW_E, DST_M, TNEW_M);
    rt_hit = src_hazard(rt_d, rt_use, tuse_rt, DST_E, TNEW_E, DST_M, TNEW_M);
  end

  assign stall_md = is_md && MD_BUSY;
  assign STALL    = rs_hit || rt_hit || stall_md;

  // D -> E -> M -> W tag pipeline; a stall only turns the E load into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DST_E  <= '0;
      TNEW_E <= '0;
      DST_M  <= '0;
      TNEW_M <= '0;
      DST_W  <= '0;
    end else begin
      DST_E  <= STALL ? '0 : dec_dst;
      TNEW_E <= STALL ? '0 : dec_tnew;
      DST_M  <= DST_E;
      TNEW_M <= (TNEW_E != '0) ? TNEW_E - 2'd1 : '0;
      DST_W  <= DST_M;
    end
  end

`ifdef MULTDIV_EN
  logic [MD_CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (!STALL && is_mult) begin
      md_cnt <= MD_CNT_W'(MULT_CYCLES);
    end else if (!STALL && is_div) begin
      md_cnt <= MD_CNT_W'(DIV_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign MD_BUSY = (md_cnt != '0);
`else
  logic unused_md;

  assign MD_BUSY   = 1'b0;
  assign unused_md = ^{is_mult, is_div, MULT_CYCLES[0], DIV_CYCLES[0], MD_CNT_W[0]};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected tags are queued at
// drive time and retired against DST_W, with directed hazard scenarios.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_D;
  logic        STALL;
  logic [4:0]  DST_E, DST_M, DST_W;
  logic [1:0]  TNEW_E, TNEW_M;
  logic        MD_BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] dst;
    int         tn;
  } ent_t;

  ent_t q[$];
  int   md_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IR_D    (IR_D),
    .STALL   (STALL),
    .DST_E   (DST_E),
    .DST_M   (DST_M),
    .DST_W   (DST_W),
    .TNEW_E  (TNEW_E),
    .TNEW_M  (TNEW_M),
    .MD_BUSY (MD_BUSY)
  );

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference decode: use = -1 means the source is not read.
  function automatic void ref_dec(input logic [31:0] ir, output logic [4:0] d, output int tn,
                                  output int urs, output int urt, output bit md, output int ld);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    d = 5'd0; tn = 0; urs = -1; urt = -1; md = 1'b0; ld = 0;
    case (op)
      6'h00: begin
        if (fn == 6'h08) urs = 0;
        else if (fn != 6'h00) begin
`ifdef MULTDIV_EN
          if (fn == 6'h18 || fn == 6'h19) begin md = 1; urs = 1; urt = 1; ld = 5; end
          else if (fn == 6'h1A || fn == 6'h1B) begin md = 1; urs = 1; urt = 1; ld = 10; end
          else if (fn == 6'h11 || fn == 6'h13) begin md = 1; urs = 1; end
          else begin
            d = ir[15:11]; tn = 1; urs = 1; urt = 1;
            md = (fn == 6'h10 || fn == 6'h12);
          end
`else
          d = ir[15:11]; tn = 1; urs = 1; urt = 1;
`endif
        end
      end
      6'h0D, 6'h0F: begin d = ir[20:16]; tn = 1; urs = 1; end
      6'h23:        begin d = ir[20:16]; tn = 2; urs = 1; end
      6'h2B:        begin urs = 1; urt = 2; end
      6'h04:        begin urs = 0; urt = 0; end
      6'h03:        begin d = 5'd31; tn = 0; end
      default: ;
    endcase
  endfunction

  function automatic bit src_stall(input logic [4:0] r, input int use_t);
    int mtn;
    mtn = (q[0].tn > 0) ? q[0].tn - 1 : 0;
    if (use_t < 0 || r == 5'd0) return 1'b0;
    return (r == q[1].dst && q[1].tn > use_t) || (r == q[0].dst && mtn > use_t);
  endfunction

  function automatic int model_stall(input logic [31:0] ir);
    logic [4:0] d;
    int tn, urs, urt, ld;
    bit md;
    ref_dec(ir, d, tn, urs, urt, md, ld);
    return (src_stall(ir[25:21], urs) || src_stall(ir[20:16], urt) || (md && md_cnt != 0)) ? 1 : 0;
  endfunction

  task automatic reset_model();
    q.delete();
    q.push_back('{5'd0, 0});
    q.push_back('{5'd0, 0});
    md_cnt = 0;
  endtask

  // Drive one D instruction for one cycle; exp_stall < 0 defers to the model.
  task automatic step(input logic [31:0] ir, input int exp_stall);
    ent_t ne, w;
    logic [4:0] d;
    int tn, urs, urt, ld, want, mtn;
    bit md;
    logic [19:0] got_v, exp_v;
    IR_D = ir;
    #1;
    want = (exp_stall < 0) ? model_stall(ir) : exp_stall;
    total++;
    if (STALL !== want[0]) begin
      bad++;
      $display("FAIL stall ir=%h got=%0b want=%0d t=%0t", ir, STALL, want, $time);
    end
    ref_dec(ir, d, tn, urs, urt, md, ld);
    ne = (want != 0) ? '{5'd0, 0} : '{d, tn};
    if (want == 0 && ld != 0) md_cnt = ld;
    else if (md_cnt > 0) md_cnt--;
    @(posedge clk);
    #1;
    w = q.pop_front();
    q.push_back(ne);
    mtn = (q[0].tn > 0) ? q[0].tn - 1 : 0;
    exp_v = {w.dst, q[0].dst, 2'(mtn), q[1].dst, 2'(q[1].tn), md_cnt != 0};
    got_v = {DST_W, DST_M, TNEW_M, DST_E, TNEW_E, MD_BUSY};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL pipe ir=%h got={W,M,TM,E,TE,B}=%h want=%h t=%0t", ir, got_v, exp_v, $time);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    IR_D  = 32'h0;
    #3;
    total++;
    if ({DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL} !== 20'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", {DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL});
    end
    IR_D = rtype(6'h20, 5'd1, 5'd2, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL} !== 20'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0", {DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL});
    end
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_load_use();
    drain(2);
    step(itype(6'h23, 5'd0, 5'd1, 16'd0), 0);
    step(rtype(6'h20, 5'd1, 5'd3, 5'd2), 1);
    total++;
    if (DST_E !== 5'd0) begin
      bad++;
      $display("FAIL load_use_bubble DST_E got=%0d want=0", DST_E);
    end
    step(rtype(6'h20, 5'd1, 5'd3, 5'd2), 0);
  endtask

  task automatic test_branch_dep();
    drain(2);
    step(itype(6'h0D, 5'd0, 5'd5, 16'd1), 0);
    step(itype(6'h04, 5'd5, 5'd0, 16'd0), 1);
    step(itype(6'h04, 5'd5, 5'd0, 16'd0), 0);
    drain(2);
    step(itype(6'h0D, 5'd0, 5'd5, 16'd1), 0);
    step(rtype(6'h20, 5'd6, 5'd7, 5'd8), 0);
    step(itype(6'h04, 5'd5, 5'd0, 16'd0), 0);
  endtask

  task automatic test_m_and_w_match();
    drain(2);
    step(itype(6'h23, 5'd0, 5'd9, 16'd0), 0);
    drain(1);
    step(itype(6'h04, 5'd9, 5'd0, 16'd0), 1);
    step(itype(6'h04, 5'd9, 5'd0, 16'd0), 0);
    drain(2);
    step(itype(6'h23, 5'd0, 5'd9, 16'd0), 0);
    drain(2);
    step(itype(6'h04, 5'd0, 5'd9, 16'd0), 0);
  endtask

  task automatic test_reg_zero();
    drain(2);
    step(itype(6'h23, 5'd0, 5'd0, 16'd4), 0);
    step(rtype(6'h20, 5'd0, 5'd0, 5'd2), 0);
  endtask

  task automatic test_jal_jr();
    drain(2);
    step(itype(6'h03, 5'd0, 5'd0, 16'h10), 0);
    total++;
    if (DST_E !== 5'd31 || TNEW_E !== 2'd0) begin
      bad++;
      $display("FAIL jal_tag got dst=%0d tnew=%0d want dst=31 tnew=0", DST_E, TNEW_E);
    end
    step(rtype(6'h08, 5'd31, 5'd0, 5'd0), 0);
  endtask

`ifdef MULTDIV_EN
  task automatic test_multdiv();
    drain(12);
    step(rtype(6'h18, 5'd1, 5'd2, 5'd0), 0);
    for (int i = 0; i < 5; i++) step(rtype(6'h12, 5'd0, 5'd0, 5'd4), 1);
    total++;
    if (MD_BUSY !== 1'b0) begin
      bad++;
      $display("FAIL mult_busy_end got=%0b want=0", MD_BUSY);
    end
    step(rtype(6'h12, 5'd0, 5'd0, 5'd4), 0);
    step(rtype(6'h1A, 5'd1, 5'd2, 5'd0), 0);
    for (int i = 0; i < 10; i++) step(rtype(6'h10, 5'd0, 5'd0, 5'd5), 1);
    total++;
    if (MD_BUSY !== 1'b0) begin
      bad++;
      $display("FAIL div_busy_end got=%0b want=0", MD_BUSY);
    end
    step(rtype(6'h10, 5'd0, 5'd0, 5'd5), 0);
  endtask
`else
  task automatic test_md_default();
    drain(2);
    step(rtype(6'h18, 5'd1, 5'd2, 5'd7), 0);
    total++;
    if (DST_E !== 5'd7 || TNEW_E !== 2'd1 || MD_BUSY !== 1'b0) begin
      bad++;
      $display("FAIL md_as_cal_r got dst=%0d tnew=%0d busy=%0b want 7 1 0", DST_E, TNEW_E, MD_BUSY);
    end
    step(rtype(6'h20, 5'd7, 5'd0, 5'd3), 0);
  endtask
`endif

  task automatic test_random();
    logic [31:0] ir;
    logic [4:0]  a, b, c;
    for (int i = 0; i < 80; i++) begin
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0: ir = rtype(6'h20, a, b, c);
        1: ir = itype(6'h0D, a, b, 16'h1);
        2: ir = itype(6'h23, a, b, 16'h0);
        3: ir = itype(6'h2B, a, b, 16'h0);
        4: ir = itype(6'h04, a, b, 16'h0);
        5: ir = rtype(6'h08, a, 5'd0, 5'd0);
        6: ir = itype(6'h03, 5'd0, 5'd0, 16'h4);
        7: ir = rtype(6'h18, a, b, 5'd0);
        8: ir = rtype(6'h1A, a, b, 5'd0);
        9: ir = rtype(6'h12, 5'd0, 5'd0, c);
        10: ir = rtype(6'h11, a, 5'd0, 5'd0);
        default: ir = 32'h0;
      endcase
      step(ir, -1);
    end
  endtask

  task automatic test_reset_mid();
    drain(12);
`ifdef MULTDIV_EN
    step(rtype(6'h1A, 5'd1, 5'd2, 5'd0), 0);
`endif
    step(itype(6'h0D, 5'd0, 5'd5, 16'd1), 0);
    step(itype(6'h23, 5'd0, 5'd6, 16'd0), 0);
    #2;
    rst_n = 1'b0;
    IR_D  = rtype(6'h12, 5'd0, 5'd0, 5'd4);
    #1;
    total++;
    if ({DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid got=%h want=0", {DST_E, DST_M, DST_W, TNEW_E, TNEW_M, MD_BUSY, STALL});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    step(rtype(6'h20, 5'd5, 5'd6, 5'd7), 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_dep();
    test_m_and_w_match();
    test_reg_zero();
    test_jal_jr();
`ifdef MULTDIV_EN
    test_multdiv();
`else
    test_md_default();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
